id_scan_arb: RTL

Round-robin controller that shares one identifier-scan engine between two character-stream requesters. It grants a whole string (up to and including its `last` character) to one requester at a time. While granted, it runs the team's identifier rule on each accepted character: an uppercase letter arms the engine, a digit while armed is a hit, and any other character disarms it. At end of string it reports the saturating hit count with the source ID on a valid/ready result port.

---
 rtl/id_scan_arb.sv | 153 +++++++++++++++
 1 files changed

// File: rtl/id_scan_arb.sv
`default_nettype none
// ============================================================================
// Module      : id_scan_arb
// Description : Round-robin arbiter sharing one identifier-scan engine between
//               two character-stream requesters. A whole string is granted to
//               one requester; uppercase arms, digit-while-armed is a hit,
//               anything else disarms. The saturating hit count and source ID
//               are reported on a valid/ready result port.
// Revision    : 1.0 - initial release
// ============================================================================
module id_scan_arb #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req0_valid,
    input  logic [7:0]       req0_char,
    input  logic             req0_last,
    output logic             req0_ready,
    input  logic             req1_valid,
    input  logic [7:0]       req1_char,
    input  logic             req1_last,
    output logic             req1_ready,
    output logic             res_valid,
    output logic             res_src,
    output logic [CNT_W-1:0] res_hits,
    input  logic             res_ready
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SCAN   = 2'd1,
        REPORT = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] HITS_ONE = CNT_W'(1);
    localparam logic [CNT_W-1:0] HITS_MAX = {CNT_W{1'b1}};

    state_t           state;
    state_t           state_next;
    logic             grant;
    logic             last_srv;
    logic             flag;
    logic [CNT_W-1:0] hits;

    logic             sel_valid;
    logic [7:0]       sel_char;
    logic             sel_last;
    logic             accept;
    logic             is_letter;
    logic             is_digit;
    logic             hit;
    logic [CNT_W-1:0] hits_next;

    // Route the granted requester's stream into the scan engine and classify it
    always_comb begin
        sel_valid = grant ? req1_valid : req0_valid;
        sel_char  = grant ? req1_char  : req0_char;
        sel_last  = grant ? req1_last  : req0_last;
        accept    = (state == SCAN) && sel_valid;
        is_letter = (sel_char >= 8'd65) && (sel_char <= 8'd90);
        is_digit  = (sel_char >= 8'd48) && (sel_char <= 8'd57);
        // flag is the pre-character value, so a letter never hits itself
        hit       = accept && is_digit && flag;
        hits_next = (hit && (hits != HITS_MAX)) ? (hits + HITS_ONE) : hits;
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic; readies and result-valid are pure state decodes
    always_comb begin
        state_next = state;
        req0_ready = 1'b0;
        req1_ready = 1'b0;
        res_valid  = 1'b0;
        case (state)
            IDLE: begin
                if (req0_valid || req1_valid) begin
                    state_next = SCAN;
                end
            end
            SCAN: begin
                req0_ready = ~grant;
                req1_ready = grant;
                if (accept && sel_last) begin
                    state_next = REPORT;
                end
            end
            REPORT: begin
                res_valid = 1'b1;
                if (res_ready) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Arbitration, scan datapath and result latching
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            grant    <= 1'b0;
            last_srv <= 1'b1;
            flag     <= 1'b0;
            hits     <= '0;
            res_src  <= 1'b0;
            res_hits <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (req0_valid || req1_valid) begin
                        // Contention goes to whoever was not served last
                        grant <= (req0_valid && req1_valid) ? ~last_srv : req1_valid;
                        flag  <= 1'b0;
                        hits  <= '0;
                    end
                end
                SCAN: begin
                    if (accept) begin
                        if (is_letter) begin
                            flag <= 1'b1;
                        end else if (!is_digit) begin
                            flag <= 1'b0;
                        end
                        hits <= hits_next;
                        if (sel_last) begin
                            res_hits <= hits_next;
                            res_src  <= grant;
                        end
                    end
                end
                REPORT: begin
                    if (res_ready) begin
                        last_srv <= grant;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule
`default_nettype wire
